hdmi_period_scheduler: RTL and testbench

Period sequencer for the HDMI transmit path. It owns the pixel counters and the sync generation. Every pixel clock it selects the TMDS encoder mode (control, video preamble/guard, video, data-island preamble/guard/packet) and drives the per-channel control bits. It also pulls 32-beat info packets from an upstream packet queue into horizontal blanking. It sits between the video timing/pixel source and the three tmds_encoder instances feeding hdmi_phy.

---
 rtl/hdmi_period_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: pixel counters, sync generation and per-pixel TMDS period selection
// (control, video preamble/guard, video, data-island preamble/guard/packet) for one HDMI link.
module hdmi_period_scheduler #(
  parameter int VIDEO_ID_CODE = 1,
  parameter int BIT_WIDTH     = 11,
  parameter int BIT_HEIGHT    = 10,
  parameter int ISLAND_START  = 20,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic [4:0]            pkt_count,
  output logic                  pkt_ready,
  output logic [4:0]            island_beat,
  output logic [2:0]            mode,
  output logic [5:0]            ctrl,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_active,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy
);

  localparam int FRAME_W  = (VIDEO_ID_CODE == 4) ? 1650 : (VIDEO_ID_CODE == 1) ? 800 : 858;
  localparam int FRAME_H  = (VIDEO_ID_CODE == 4) ? 750 : 525;
  localparam int SCREEN_W = (VIDEO_ID_CODE == 4) ? 1280 : (VIDEO_ID_CODE == 1) ? 640 : 720;
  localparam int SCREEN_H = (VIDEO_ID_CODE == 4) ? 720 : 480;
  localparam int HS_FIRST = (VIDEO_ID_CODE == 4) ? 110 : 16;
  localparam int HS_LAST  = (VIDEO_ID_CODE == 4) ? 149 : (VIDEO_ID_CODE == 1) ? 111 : 77;
  localparam int VS_FIRST = (VIDEO_ID_CODE == 4) ? 5 : (VIDEO_ID_CODE == 1) ? 10 : 9;
  localparam int VS_LAST  = (VIDEO_ID_CODE == 4) ? 9 : (VIDEO_ID_CODE == 1) ? 11 : 14;
  localparam logic SYNC_ON = (VIDEO_ID_CODE == 4);
  localparam int START_X  = FRAME_W - SCREEN_W;
  localparam int START_Y  = FRAME_H - SCREEN_H;

  // Packet k fits when ISLAND_START + 10 + 32(k+1) + 2 + 12 <= START_X.
  localparam int FIT_ROOM  = START_X - ISLAND_START - 24;
  localparam int FIT_PKTS  = (FIT_ROOM >= 32) ? FIT_ROOM / 32 : 0;
  localparam int PKT_LIMIT = (FIT_PKTS < MAX_PACKETS) ? FIT_PKTS : MAX_PACKETS;
  localparam logic ISLAND_OK = (PKT_LIMIT >= 1);
  localparam logic [4:0] LAST_PKT = ISLAND_OK ? 5'(PKT_LIMIT - 1) : 5'd0;

  localparam logic [BIT_WIDTH-1:0]  X_LAST  = BIT_WIDTH'(FRAME_W - 1);
  localparam logic [BIT_WIDTH-1:0]  X_START = BIT_WIDTH'(START_X);
  localparam logic [BIT_WIDTH-1:0]  X_GUARD = BIT_WIDTH'(START_X - 2);
  localparam logic [BIT_WIDTH-1:0]  X_VPRE  = BIT_WIDTH'(START_X - 10);
  localparam logic [BIT_WIDTH-1:0]  X_ISL   = BIT_WIDTH'(ISLAND_START);
  localparam logic [BIT_WIDTH-1:0]  X_HS0   = BIT_WIDTH'(HS_FIRST);
  localparam logic [BIT_WIDTH-1:0]  X_HS1   = BIT_WIDTH'(HS_LAST);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST  = BIT_HEIGHT'(FRAME_H - 1);
  localparam logic [BIT_HEIGHT-1:0] Y_START = BIT_HEIGHT'(START_Y);
  localparam logic [BIT_HEIGHT-1:0] Y_VS0   = BIT_HEIGHT'(VS_FIRST);
  localparam logic [BIT_HEIGHT-1:0] Y_VS1   = BIT_HEIGHT'(VS_LAST);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGUARD = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LG, S_PKT, S_TG} island_state_t;

  island_state_t state, cur_state, next_state;
  logic [4:0] cnt, cur_cnt, next_cnt;
  logic [4:0] pkt_idx, cur_idx, next_idx;
  logic [2:0] mode_d;
  logic [3:0] ctl_d;
  logic [4:0] beat_d;
  logic       ready_d, hsync_d, vsync_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      cx <= '0;
      cy <= '0;
    end else if (cx == X_LAST) begin
      cx <= '0;
      cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
    end else begin
      cx <= cx + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pkt_idx <= '0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      pkt_idx <= next_idx;
    end
  end

  // The island entry decision belongs to the cx==ISLAND_START pixel itself, so PRE starts there.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_state = state;
    cur_cnt   = cnt;
    cur_idx   = pkt_idx;
    if (ISLAND_OK && state == S_IDLE && cx == X_ISL && pkt_count != 5'd0) begin
      cur_state = S_PRE;
      cur_cnt   = '0;
      cur_idx   = '0;
    end
  end

  always_comb begin
    next_state = cur_state;
    next_cnt   = cur_cnt + 5'd1;
    next_idx   = cur_idx;
    case (cur_state)
      S_IDLE: next_cnt = '0;
      S_PRE: if (cur_cnt == 5'd7) begin
        next_state = S_LG;
        next_cnt   = '0;
      end
      S_LG: if (cur_cnt == 5'd1) begin
        next_state = S_PKT;
        next_cnt   = '0;
      end
      S_PKT: if (cur_cnt == 5'd31) begin
        next_cnt = '0;
        if (pkt_count >= 5'd2 && cur_idx < LAST_PKT) next_idx = cur_idx + 5'd1;
        else next_state = S_TG;
      end
      S_TG: if (cur_cnt == 5'd1) begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    mode_d  = MODE_CTRL;
    ctl_d   = 4'b0000;
    beat_d  = '0;
    ready_d = 1'b0;
    hsync_d = (cx >= X_HS0 && cx <= X_HS1) ? SYNC_ON : ~SYNC_ON;
    vsync_d = (cy >= Y_VS0 && cy <= Y_VS1) ? SYNC_ON : ~SYNC_ON;
    if (cy >= Y_START) begin
      if (cx >= X_START)      mode_d = MODE_VIDEO;
      else if (cx >= X_GUARD) mode_d = MODE_VGUARD;
      else if (cx >= X_VPRE)  ctl_d  = 4'b0001;
    end
    case (cur_state)
      S_PRE:      ctl_d  = 4'b0101;
      S_LG, S_TG: mode_d = MODE_IGUARD;
      S_PKT: begin
        mode_d  = MODE_ISLAND;
        beat_d  = cur_cnt;
        ready_d = (cur_cnt == 5'd31);
      end
      default: ;
    endcase
  end

  // Outputs are registered from the current cx/cy, so they trail the counters by one pixel.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      mode         <= MODE_CTRL;
      ctrl         <= {4'b0000, ~SYNC_ON, ~SYNC_ON};
      hsync        <= ~SYNC_ON;
      vsync        <= ~SYNC_ON;
      video_active <= 1'b0;
      island_beat  <= '0;
      pkt_ready    <= 1'b0;
    end else begin
      mode         <= mode_d;
      ctrl         <= {ctl_d, vsync_d, hsync_d};
      hsync        <= hsync_d;
      vsync        <= vsync_d;
      video_active <= (mode_d == MODE_VIDEO);
      island_beat  <= beat_d;
      pkt_ready    <= ready_d;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// tb_hdmi_period_scheduler: directed table-driven checks of three scheduler configurations
// (640x480, 640x480 limited to 2 packets per island, 1280x720) plus reset/sync-length sequences.
module tb_hdmi_period_scheduler;

  logic clk_pixel = 1'b0;
  logic rst = 1'b1;
  logic [4:0] pkt1 = 5'd0;
  logic [4:0] pkt_mp = 5'd5;
  logic [4:0] pkt4 = 5'd0;
  logic late_island = 1'b0;
  int tick = 0;
  int n_tests = 0;
  int n_fail = 0;

  logic rdy [3];
  logic [4:0] beat [3];
  logic [2:0] mode [3];
  logic [5:0] ctrl [3];
  logic hs [3], vs [3], va [3];
  logic [10:0] cx [3];
  logic [9:0] cy [3];

  always #5 clk_pixel = ~clk_pixel;

  // Pixels elapsed since reset release; outputs sampled at a negedge describe pixel tick-1.
  always @(posedge clk_pixel) tick <= rst ? 0 : tick + 1;

  hdmi_period_scheduler #(.VIDEO_ID_CODE(1)) u_dut1 (
    .clk_pixel(clk_pixel), .rst(rst), .pkt_count(pkt1), .pkt_ready(rdy[0]),
    .island_beat(beat[0]), .mode(mode[0]), .ctrl(ctrl[0]), .hsync(hs[0]), .vsync(vs[0]),
    .video_active(va[0]), .cx(cx[0]), .cy(cy[0]));

  hdmi_period_scheduler #(.VIDEO_ID_CODE(1), .MAX_PACKETS(2)) u_dut_mp (
    .clk_pixel(clk_pixel), .rst(rst), .pkt_count(pkt_mp), .pkt_ready(rdy[1]),
    .island_beat(beat[1]), .mode(mode[1]), .ctrl(ctrl[1]), .hsync(hs[1]), .vsync(vs[1]),
    .video_active(va[1]), .cx(cx[1]), .cy(cy[1]));

  hdmi_period_scheduler #(.VIDEO_ID_CODE(4)) u_dut4 (
    .clk_pixel(clk_pixel), .rst(rst), .pkt_count(pkt4), .pkt_ready(rdy[2]),
    .island_beat(beat[2]), .mode(mode[2]), .ctrl(ctrl[2]), .hsync(hs[2]), .vsync(vs[2]),
    .video_active(va[2]), .cx(cx[2]), .cy(cy[2]));

  typedef struct {
    int         dut;
    int         p;
    logic [2:0] mode;
    logic [3:0] ctl;
    logic [4:0] beat;
    logic       ready;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int d, int p, int m, int c, int b, int r, string n);
    vec_t v;
    v.dut = d; v.p = p; v.mode = 3'(m); v.ctl = 4'(c); v.beat = 5'(b); v.ready = 1'(r); v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic logic [4:0] pkt1_for(int t);
    int ln;
    ln = t / 800;
    if (late_island) return 5'd1;
    if (ln == 1 || ln == 46) return 5'd1;
    if (ln == 2) return 5'd5;
    return 5'd0;
  endfunction

  function automatic logic hs_model(int d, int p);
    int x;
    if (d == 2) begin
      x = p % 1650;
      return (x >= 110 && x <= 149);
    end
    x = p % 800;
    return !(x >= 16 && x <= 111);
  endfunction

  function automatic logic vs_model(int d, int p);
    int y;
    if (d == 2) begin
      y = (p / 1650) % 750;
      return (y >= 5 && y <= 9);
    end
    y = (p / 800) % 525;
    return !(y >= 10 && y <= 11);
  endfunction

  function automatic logic [63:0] pack(logic [2:0] m, logic [5:0] c, logic h, logic v, logic a,
                                       logic [4:0] b, logic r, logic [10:0] x, logic [9:0] y);
    return {25'd0, m, c, h, v, a, b, r, x, y};
  endfunction

  function automatic logic [63:0] sample(int d);
    return pack(mode[d], ctrl[d], hs[d], vs[d], va[d], beat[d], rdy[d], cx[d], cy[d]);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_pixel);
    pkt1 = pkt1_for(tick);
  endtask

  task automatic goto(input int p);
    while (tick - 1 < p) step();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, tick %0d", tick);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, h, cnt;
    logic [63:0] exp;
    logic found;

    // dut 0: code 1; dut 1: code 1, MAX_PACKETS=2, pkt_count=5; dut 2: code 4.
    add(0, 15, 0, 0, 0, 0, "l0_hs_before");
    add(0, 16, 0, 0, 0, 0, "l0_hs_first");
    add(0, 20, 0, 0, 0, 0, "l0_no_island");
    add(1, 20, 0, 5, 0, 0, "mp_pre_first");
    add(1, 27, 0, 5, 0, 0, "mp_pre_last");
    add(1, 28, 4, 0, 0, 0, "mp_lg");
    add(1, 61, 3, 0, 31, 1, "mp_ready0");
    add(1, 62, 3, 0, 0, 0, "mp_pkt1_beat0");
    add(1, 93, 3, 0, 31, 1, "mp_ready1");
    add(1, 94, 4, 0, 0, 0, "mp_tg0");
    add(1, 95, 4, 0, 0, 0, "mp_tg1");
    add(1, 96, 0, 0, 0, 0, "mp_idle");
    add(2, 109, 0, 0, 0, 0, "v4_hs_before");
    add(2, 110, 0, 0, 0, 0, "v4_hs_first");
    add(0, 111, 0, 0, 0, 0, "l0_hs_last");
    add(0, 112, 0, 0, 0, 0, "l0_hs_after");
    add(2, 149, 0, 0, 0, 0, "v4_hs_last");
    add(2, 150, 0, 0, 0, 0, "v4_hs_after");
    add(0, 155, 0, 0, 0, 0, "l0_blank_no_preamble");
    add(0, 170, 0, 0, 0, 0, "l0_blank_no_video");
    add(0, 799, 0, 0, 0, 0, "l0_wrap");
    add(0, 819, 0, 0, 0, 0, "l1_before_island");
    add(0, 820, 0, 5, 0, 0, "l1_pre_first");
    add(0, 827, 0, 5, 0, 0, "l1_pre_last");
    add(0, 828, 4, 0, 0, 0, "l1_lg0");
    add(0, 829, 4, 0, 0, 0, "l1_lg1");
    add(0, 830, 3, 0, 0, 0, "l1_beat0");
    add(0, 845, 3, 0, 15, 0, "l1_beat15");
    add(0, 860, 3, 0, 30, 0, "l1_beat30");
    add(0, 861, 3, 0, 31, 1, "l1_ready");
    add(0, 862, 4, 0, 0, 0, "l1_tg0");
    add(0, 863, 4, 0, 0, 0, "l1_tg1");
    add(0, 864, 0, 0, 0, 0, "l1_idle");
    add(0, 1661, 3, 0, 31, 1, "l2_ready0");
    add(0, 1662, 3, 0, 0, 0, "l2_pkt1");
    add(0, 1693, 3, 0, 31, 1, "l2_ready1");
    add(0, 1725, 3, 0, 31, 1, "l2_ready2");
    add(0, 1726, 4, 0, 0, 0, "l2_tg0");
    add(0, 1727, 4, 0, 0, 0, "l2_tg1");
    add(0, 1728, 0, 0, 0, 0, "l2_ctrl_after");
    add(0, 1749, 0, 0, 0, 0, "l2_ctrl_149");
    add(2, 6600, 0, 0, 0, 0, "v4_vs_before");
    add(0, 7200, 0, 0, 0, 0, "l9_vs_inactive");
    add(0, 8000, 0, 0, 0, 0, "l10_vs_first");
    add(2, 8250, 0, 0, 0, 0, "v4_vs_first");
    add(0, 9599, 0, 0, 0, 0, "l11_vs_last");
    add(0, 9600, 0, 0, 0, 0, "l12_vs_after");
    add(2, 16499, 0, 0, 0, 0, "v4_vs_last");
    add(2, 16500, 0, 0, 0, 0, "v4_vs_after");
    add(0, 35999, 0, 0, 0, 0, "l44_blank_end");
    add(0, 36000, 0, 0, 0, 0, "l45_start");
    add(0, 36149, 0, 0, 0, 0, "l45_before_pre");
    add(0, 36150, 0, 1, 0, 0, "l45_pre_first");
    add(0, 36157, 0, 1, 0, 0, "l45_pre_last");
    add(0, 36158, 2, 0, 0, 0, "l45_guard0");
    add(0, 36159, 2, 0, 0, 0, "l45_guard1");
    add(0, 36160, 1, 0, 0, 0, "l45_video_first");
    add(0, 36799, 1, 0, 0, 0, "l45_video_last");
    add(0, 36820, 0, 5, 0, 0, "l46_island_pre");
    add(0, 36830, 3, 0, 0, 0, "l46_island_pkt");
    add(0, 36861, 3, 0, 31, 1, "l46_ready");
    add(0, 36950, 0, 1, 0, 0, "l46_video_pre");
    add(0, 36960, 1, 0, 0, 0, "l46_video");
    add(2, 49859, 0, 0, 0, 0, "v4_before_pre");
    add(2, 49860, 0, 1, 0, 0, "v4_pre_first");
    add(2, 49867, 0, 1, 0, 0, "v4_pre_last");
    add(2, 49868, 2, 0, 0, 0, "v4_guard0");
    add(2, 49869, 2, 0, 0, 0, "v4_guard1");
    add(2, 49870, 1, 0, 0, 0, "v4_video_first");
    add(2, 51149, 1, 0, 0, 0, "v4_video_last");

    repeat (2) step();
    check("reset_code1", sample(0), pack(3'd0, 6'b000011, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 11'd0, 10'd0));
    check("reset_mp", sample(1), pack(3'd0, 6'b000011, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 11'd0, 10'd0));
    check("reset_code4", sample(2), pack(3'd0, 6'b000000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 11'd0, 10'd0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      goto(vecs[i].p);
      w = (vecs[i].dut == 2) ? 1650 : 800;
      h = (vecs[i].dut == 2) ? 750 : 525;
      exp = pack(vecs[i].mode,
                 {vecs[i].ctl, vs_model(vecs[i].dut, vecs[i].p), hs_model(vecs[i].dut, vecs[i].p)},
                 hs_model(vecs[i].dut, vecs[i].p), vs_model(vecs[i].dut, vecs[i].p),
                 vecs[i].mode == 3'd1, vecs[i].beat, vecs[i].ready,
                 11'((vecs[i].p + 1) % w), 10'(((vecs[i].p + 1) / w) % h));
      check(vecs[i].name, sample(vecs[i].dut), exp);
    end

    // One full 640x480 line: hsync low for exactly 96 pixels.
    while (tick % 800 != 0) step();
    cnt = 0;
    repeat (800) begin
      step();
      if (hs[0] == 1'b0) cnt++;
    end
    check("hsync_low_count", 64'(cnt), 64'd96);

    // One full 1280x720 line: hsync high for exactly 40 pixels.
    while (tick % 1650 != 0) step();
    cnt = 0;
    repeat (1650) begin
      step();
      if (hs[2] == 1'b1) cnt++;
    end
    check("v4_hsync_high_count", 64'(cnt), 64'd40);

    // Reset while a packet is at beat 10.
    late_island = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (mode[0] == 3'd3 && beat[0] == 5'd10) found = 1'b1;
    end
    check("beat10_reached", 64'(found), 64'd1);
    rst = 1'b1;
    late_island = 1'b0;
    pkt1 = 5'd0;
    @(negedge clk_pixel);
    check("reset_mid_island", sample(0),
          pack(3'd0, 6'b000011, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 11'd0, 10'd0));
    rst = 1'b0;
    goto(2);
    check("restart_idle", sample(0),
          pack(3'd0, 6'b000011, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 11'd3, 10'd0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
